// File: rtl/boid_frame_writer_if.sv
// Boid frame writer bus: BPU read-mux select/position and display RAM write port.
interface boid_frame_writer_if #(
  parameter int BITS_FOR_BOIDS = 2,
  parameter int ADDR_WIDTH     = 19
);
  logic [BITS_FOR_BOIDS-1:0] boid_sel;
  logic [9:0]                x_loc;
  logic [8:0]                y_loc;
  logic                      buf_swap;
  logic                      fb_we;
  logic [ADDR_WIDTH-1:0]     fb_addr;

  modport master (
    output boid_sel, buf_swap, fb_we, fb_addr,
    input  x_loc, y_loc
  );

  modport slave (
    input  boid_sel, buf_swap, fb_we, fb_addr,
    output x_loc, y_loc
  );
endinterface

// File: rtl/boid_frame_writer.sv
// Per-frame sequencer: swap the display buffer, then draw a clipped
// SPRITE x SPRITE square for every boid into the display RAM.
module boid_frame_writer #(
  parameter int MAX_BOIDS      = 4,
  parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
  parameter int VIDEO_WIDTH    = 640,
  parameter int VIDEO_HEIGHT   = 480,
  parameter int ADDR_WIDTH     = 19,
  parameter int SPRITE         = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 screenEnd,
  boid_frame_writer_if.master  bus,
  output logic                 busy,
  output logic                 overrun,
  output logic [15:0]          frame_count
);

  localparam int H  = (SPRITE - 1) / 2;
  localparam int OW = $clog2(SPRITE + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SWAP   = 3'd1;
  localparam logic [2:0] ST_SELECT = 3'd2;
  localparam logic [2:0] ST_LATCH  = 3'd3;
  localparam logic [2:0] ST_DRAW   = 3'd4;

  localparam logic [OW-1:0]             OFF_LAST = OW'(SPRITE - 1);
  localparam logic [BITS_FOR_BOIDS-1:0] K_LAST   = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  logic [2:0]                state_q, state_d;
  logic [BITS_FOR_BOIDS-1:0] k_q, k_d;
  logic [BITS_FOR_BOIDS-1:0] boid_sel_q, boid_sel_d;
  logic [9:0]                bx_q, bx_d;
  logic [8:0]                by_q, by_d;
  logic [OW-1:0]             dx_q, dx_d, dy_q, dy_d;
  logic                      buf_swap_q, buf_swap_d;
  logic                      fb_we_q, fb_we_d;
  logic [ADDR_WIDTH-1:0]     fb_addr_q, fb_addr_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;
  logic [15:0]               frame_count_q, frame_count_d;

  // Pixel to be presented on the write port in the next cycle
  logic                      emit;
  logic [9:0]                src_x;
  logic [8:0]                src_y;
  logic [OW-1:0]             off_x, off_y;
  logic [11:0]               px, py;
  logic                      in_bounds;
  logic [ADDR_WIDTH-1:0]     pix_addr;

  // Sequencer: state walk, boid/offset counters and status flags
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    boid_sel_d    = boid_sel_q;
    bx_d          = bx_q;
    by_d          = by_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    buf_swap_d    = 1'b0;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    emit          = 1'b0;
    src_x         = bx_q;
    src_y         = by_q;
    off_x         = dx_q;
    off_y         = dy_q;

    if (screenEnd && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (screenEnd) begin
          state_d    = ST_SWAP;
          buf_swap_d = 1'b1;
          busy_d     = 1'b1;
          k_d        = '0;
        end
      end
      ST_SWAP: begin
        state_d    = ST_SELECT;
        boid_sel_d = k_q;
      end
      ST_SELECT: state_d = ST_LATCH;
      ST_LATCH: begin
        // The first offset is issued straight from the mux so that its
        // write lands in the first DRAW cycle, in step with the latch.
        bx_d    = bus.x_loc;
        by_d    = bus.y_loc;
        dx_d    = '0;
        dy_d    = '0;
        state_d = ST_DRAW;
        emit    = 1'b1;
        src_x   = bus.x_loc;
        src_y   = bus.y_loc;
        off_x   = '0;
        off_y   = '0;
      end
      ST_DRAW: begin
        if (dx_q == OFF_LAST && dy_q == OFF_LAST) begin
          if (k_q != K_LAST) begin
            k_d        = k_q + 1'b1;
            boid_sel_d = k_q + 1'b1;
            state_d    = ST_SELECT;
          end else begin
            frame_count_d = frame_count_q + 16'd1;
            busy_d        = 1'b0;
            state_d       = ST_IDLE;
          end
        end else begin
          if (dx_q == OFF_LAST) begin
            dx_d = '0;
            dy_d = dy_q + 1'b1;
          end else begin
            dx_d = dx_q + 1'b1;
          end
          emit  = 1'b1;
          off_x = dx_d;
          off_y = dy_d;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Pixel coordinate, clip test and linear address for the next write
  always_comb begin
    // Negative coordinates wrap to large unsigned values and fail the clip
    px        = {2'b00, src_x} + 12'(off_x) - 12'(H);
    py        = {3'b000, src_y} + 12'(off_y) - 12'(H);
    in_bounds = (px < 12'(VIDEO_WIDTH)) && (py < 12'(VIDEO_HEIGHT));
    pix_addr  = ADDR_WIDTH'(32'(py) * 32'(VIDEO_WIDTH) + 32'(px));
    fb_we_d   = emit && in_bounds;
    fb_addr_d = (emit && in_bounds) ? pix_addr : fb_addr_q;
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      boid_sel_q    <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      buf_swap_q    <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      boid_sel_q    <= boid_sel_d;
      bx_q          <= bx_d;
      by_q          <= by_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      buf_swap_q    <= buf_swap_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.boid_sel = boid_sel_q;
  assign bus.buf_swap = buf_swap_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_boid_frame_writer.sv
// Bench for boid_frame_writer: per-cycle trace model plus literal checks.
module tb_boid_frame_writer;
  localparam int MB = 4;
  localparam int BB = 2;
  localparam int AW = 19;
  localparam int S  = 3;
  localparam int H  = 1;
  localparam int VW = 640;
  localparam int VH = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        screenEnd = 1'b0;
  logic        busy, overrun;
  logic [15:0] frame_count;

  boid_frame_writer_if #(.BITS_FOR_BOIDS(BB), .ADDR_WIDTH(AW)) bif ();

  boid_frame_writer #(
    .MAX_BOIDS(MB), .BITS_FOR_BOIDS(BB), .VIDEO_WIDTH(VW),
    .VIDEO_HEIGHT(VH), .ADDR_WIDTH(AW), .SPRITE(S)
  ) dut (
    .clock(clk), .reset(rst), .screenEnd(screenEnd), .bus(bif.master),
    .busy(busy), .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // BPU bank stand-in: combinational read mux
  logic [9:0] pos_x [MB];
  logic [8:0] pos_y [MB];
  assign bif.x_loc = pos_x[bif.boid_sel];
  assign bif.y_loc = pos_y[bif.boid_sel];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One expected cycle of DUT behaviour
  typedef struct {
    bit busy;
    bit swap;
    bit we;
    bit sel;
    int selv;
    int addr;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  bit   prev_busy = 0;
  bit   exp_ov = 0;
  logic [15:0] exp_fc = '0;
  int   exp_sel = 0;

  int   wr_log[$];
  int   swaps = 0;
  int   busy_cyc = 0;

  function automatic ent_t mk(bit b, bit sw, bit w, bit s, int sv, int a);
    ent_t e;
    e.busy = b; e.swap = sw; e.we = w; e.sel = s; e.selv = sv; e.addr = a;
    return e;
  endfunction

  // Whole-frame expectation from the positions held at frame start
  function automatic void build_trace();
    int px, py;
    bit inb;
    q.push_back(mk(1, 1, 0, 0, 0, 0));
    for (int k = 0; k < MB; k++) begin
      q.push_back(mk(1, 0, 0, 1, k, 0));
      q.push_back(mk(1, 0, 0, 0, 0, 0));
      for (int dy = -H; dy <= H; dy++)
        for (int dx = -H; dx <= H; dx++) begin
          px  = int'(pos_x[k]) + dx;
          py  = int'(pos_y[k]) + dy;
          inb = (px >= 0) && (px < VW) && (py >= 0) && (py < VH);
          q.push_back(mk(1, 0, inb, 0, 0, inb ? (py * VW + px) : 0));
        end
    end
  endfunction

  // Model step on every edge, then compare all outputs 1 time unit later
  always begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      prev_busy = 0;
      exp_ov    = 0;
      exp_fc    = '0;
      exp_sel   = 0;
      cur       = mk(0, 0, 0, 0, 0, 0);
    end else begin
      if (screenEnd) begin
        if (prev_busy) exp_ov = 1;
        else build_trace();
      end
      if (prev_busy && q.size() == 0) exp_fc = exp_fc + 16'd1;
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(0, 0, 0, 0, 0, 0);
      if (cur.sel) exp_sel = cur.selv;
      prev_busy = cur.busy;
    end
    #1;
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("buf_swap", 32'(bif.buf_swap), 32'(cur.swap));
    chk("fb_we", 32'(bif.fb_we), 32'(cur.we));
    if (cur.we || rst) chk("fb_addr", 32'(bif.fb_addr), 32'(cur.addr));
    chk("boid_sel", 32'(bif.boid_sel), 32'(exp_sel));
    chk("overrun", 32'(overrun), 32'(exp_ov));
    chk("frame_count", 32'(frame_count), 32'(exp_fc));
    if (!rst) begin
      if (bif.fb_we) wr_log.push_back(int'(bif.fb_addr));
      if (bif.buf_swap) swaps++;
      if (busy) busy_cyc++;
    end
  end

  task automatic clear_logs();
    wr_log.delete();
    swaps = 0;
    busy_cyc = 0;
  endtask

  task automatic pulse();
    @(negedge clk) screenEnd = 1'b1;
    @(negedge clk) screenEnd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout at %0t: busy=%0d required 0", $time, busy);
    end
  endtask

  task automatic chk_log(input string name, input int exp[8], input int n);
    chk({name, "_count"}, 32'(wr_log.size()), 32'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++)
      chk(name, 32'(wr_log[i]), 32'(exp[i]));
  endtask

  task automatic set_pos(input int b, input int x, input int y);
    pos_x[b] = 10'(x);
    pos_y[b] = 9'(y);
  endtask

  int exp9 [9];
  int exp8 [8];
  int exp_a [8];
  int exp_b [8];
  int ex [5];
  int ey [5];
  int gap;
  logic [15:0] fc0;

  initial begin
    for (int b = 0; b < MB; b++) set_pos(b, 1000, 300);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fb_we", 32'(bif.fb_we), 0);
    chk("rst_fb_addr", 32'(bif.fb_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single on-screen boid at (100,50); the rest off-screen
    set_pos(0, 100, 50);
    clear_logs();
    pulse();
    wait_idle();
    @(negedge clk);
    exp9 = '{31459, 31460, 31461, 32099, 32100, 32101, 32739, 32740, 32741};
    chk("single_count", 32'(wr_log.size()), 9);
    for (int i = 0; i < 9 && i < wr_log.size(); i++) chk("single_addr", 32'(wr_log[i]), 32'(exp9[i]));
    chk("single_swaps", 32'(swaps), 1);
    chk("single_busy_cycles", 32'(busy_cyc), 45);
    chk("single_frame_count", 32'(frame_count), 1);

    // Corner clip: (0,0) and (639,479)
    set_pos(0, 0, 0);
    set_pos(1, 639, 479);
    clear_logs();
    pulse();
    wait_idle();
    @(negedge clk);
    exp8 = '{0, 1, 640, 641, 306558, 306559, 307198, 307199};
    chk_log("corner_addr", exp8, 8);
    chk("corner_busy_cycles", 32'(busy_cyc), 45);

    // Overrun: second pulse 10 cycles in, then a third while idle
    set_pos(0, 320, 240);
    set_pos(1, 1000, 300);
    fc0 = frame_count;
    clear_logs();
    pulse();
    repeat (9) @(negedge clk);
    pulse();
    wait_idle();
    @(negedge clk);
    chk("ovr_swaps", 32'(swaps), 1);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_frame_count", 32'(frame_count), 32'(fc0 + 16'd1));
    clear_logs();
    pulse();
    wait_idle();
    @(negedge clk);
    chk("ovr_third_swaps", 32'(swaps), 1);
    chk("ovr_sticky", 32'(overrun), 1);
    chk("ovr_third_writes", 32'(wr_log.size()), 9);

    // Reset during boid 2's DRAW
    for (int b = 0; b < MB; b++) set_pos(b, 50 + 100 * b, 60);
    pulse();
    repeat (27) @(negedge clk);
    chk("mid_boid_sel", 32'(bif.boid_sel), 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_fb_we", 32'(bif.fb_we), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_boid_sel", 32'(bif.boid_sel), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_frame_count", 32'(frame_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    pulse();
    wait_idle();
    @(negedge clk);
    chk("restart_first_addr", 32'(wr_log.size() > 0 ? wr_log[0] : -1), 59 * VW + 49);
    chk("restart_frame_count", 32'(frame_count), 1);

    // Randomised frames with edge-hugging positions and overlapping pulses
    ex = '{0, 1, 638, 639, 640};
    ey = '{0, 1, 478, 479, 480};
    for (int it = 0; it < 30; it++) begin
      wait_idle();
      for (int b = 0; b < MB; b++) begin
        case ($urandom_range(0, 3))
          0: set_pos(b, $urandom_range(0, 1023), $urandom_range(0, 511));
          1: set_pos(b, ex[$urandom_range(0, 4)], ey[$urandom_range(0, 4)]);
          default: set_pos(b, $urandom_range(0, 639), $urandom_range(0, 479));
        endcase
      end
      pulse();
      gap = $urandom_range(1, 60);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 1) == 1) pulse();
    end
    wait_idle();

    // Wrap: preload the counter just below the top, then run two frames
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFE;
    exp_fc = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    pulse();
    wait_idle();
    @(negedge clk);
    chk("wrap_ffff", 32'(frame_count), 32'h0000_FFFF);
    pulse();
    wait_idle();
    @(negedge clk);
    chk("wrap_zero", 32'(frame_count), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boid_frame_writer.md
# boid_frame_writer

Sequencer between the per-boid BPU bank and the resettable boid display RAM. On each VGA screen-end pulse it pulses a buffer swap. It then walks every boid: it selects the boid on the read mux, latches its position, and writes a clipped SPRITE×SPRITE square of set pixels into the display RAM. It replaces the ad-hoc boid counter loop in the top level, which wrote only one pixel per boid.

## Interface

Parameters:
- MAX_BOIDS, 4, number of BPUs walked per frame
- BITS_FOR_BOIDS, $clog2(MAX_BOIDS), boid select width
- VIDEO_WIDTH, 640, visible pixels per line
- VIDEO_HEIGHT, 480, visible lines
- ADDR_WIDTH, 19, display RAM address width
- SPRITE, 3, sprite side in pixels (odd, ≥1)

Ports:
- clock  in  1  system clock (50 MHz domain)
- reset  in  1  asynchronous, active-high
- screenEnd  in  1  one-cycle pulse from VGAController at frame end
- boid_sel  out  BITS_FOR_BOIDS  index driven to the BPU output mux
- x_loc  in  10  x of selected boid (mux output)
- y_loc  in  9  y of selected boid (mux output)
- buf_swap  out  1  one-cycle pulse to RAM_resettable.reset
- fb_we  out  1  display RAM write enable (write data is constant 1)
- fb_addr  out  ADDR_WIDTH  display RAM write address
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky: screenEnd arrived while busy
- frame_count  out  16  completed frames, wraps

## Operation

- States: IDLE, SWAP, SELECT, LATCH, DRAW.
- IDLE: on screenEnd go to SWAP. Otherwise hold.
- SWAP (1 cycle):
  - buf_swap=1.
  - boid index k=0.
  - Go to SELECT.
- SELECT (1 cycle):
  - boid_sel=k.
  - Mux output settles.
  - Go to LATCH.
- LATCH (1 cycle):
  - Register x_loc→bx and y_loc→by.
  - Zero the sprite offsets dx and dy.
  - Go to DRAW.
- DRAW (SPRITE² cycles):
  - Offsets run dx,dy ∈ [−H,+H], where H=(SPRITE−1)/2.
  - Order is row-major: dx increments fastest, then dy.
  - Each cycle computes px=bx+dx and py=by+dy as 11-bit signed values.
  - In-bounds test: 0≤px<VIDEO_WIDTH and 0≤py<VIDEO_HEIGHT.
  - If in bounds: fb_we=1 and fb_addr=py*VIDEO_WIDTH+px, truncated to ADDR_WIDTH.
  - Otherwise fb_we=0 and the cycle is still consumed.
  - After the last offset: if k<MAX_BOIDS−1, increment k and go to SELECT.
  - Else increment frame_count (mod 2¹⁶) and go to IDLE.
- boid_sel holds its value in every state except SELECT, where it updates to k.
- Multiply: VIDEO_WIDTH is constant, so shift-add is acceptable. The result must be exact for py≤479 and px≤639.
- Out-of-range positions from a BPU (x≥640 or y≥480) are clipped pixel by pixel, never wrapped.
- screenEnd while busy:
  - The pulse is ignored, with no restart and no second buf_swap.
  - overrun is set to 1 and stays set until reset.
- screenEnd coinciding with the final DRAW cycle counts as busy: overrun is set and the frame is dropped.
- Reset mid-operation:
  - All state clears immediately.
  - No further fb_we.
  - The partial frame is abandoned.

## Timing

- Reset values:
  - state=IDLE, boid_sel=0, buf_swap=0, fb_we=0, fb_addr=0.
  - busy=0, overrun=0, frame_count=0.
  - k=0, bx=by=0.
- All outputs are registered. fb_we and fb_addr change together and are valid in the same cycle.
- screenEnd sampled high at edge T in IDLE:
  - buf_swap is high during cycle T+1.
  - boid_sel=0 at T+2.
  - Position is latched at edge T+3.
  - First fb_we is possible at cycle T+4.
- Per-boid cost is 2+SPRITE² cycles.
- Frame cost is 1+MAX_BOIDS·(2+SPRITE²). With defaults this is 45 cycles, well inside vertical blanking.
- The display RAM sees buf_swap at least 2 cycles before the first write.
- busy rises with SWAP and falls the cycle after the last DRAW cycle. frame_count updates on that same edge.

## Test plan

- Single boid, defaults:
  - Stimulus: boid 0 at (100,50), screenEnd pulse.
  - Required: buf_swap exactly one cycle.
  - Required boid 0 writes, in order: 31459, 31460, 31461, 32099, 32100, 32101, 32739, 32740, 32741.
  - Required: busy for exactly 45 cycles; frame_count=1.
- Corner clip:
  - Stimulus: boid at (0,0).
  - Required: fb_we high only for addresses 0, 1, 640, 641.
  - Stimulus: boid at (639,479).
  - Required: only 306558, 306559, 307198, 307199.
  - Each such boid still takes 11 cycles.
- Off-screen:
  - Stimulus: boid at x=1000, y=300.
  - Required: zero writes for that boid; other boids unaffected.
- Overrun:
  - Stimulus: a second screenEnd 10 cycles after the first.
  - Required: no extra buf_swap, overrun=1, one frame completes, frame_count=1.
  - Stimulus: a third pulse while idle.
  - Required: normal frame, overrun stays 1.
- Reset mid-DRAW:
  - Stimulus: assert reset during boid 2's DRAW.
  - Required: fb_we=0 immediately and all outputs at reset values.
  - Stimulus: next screenEnd after release.
  - Required: restarts at boid 0.
- Wrap:
  - Stimulus: preload or run 65536 frames.
  - Required: frame_count returns to 0.
